// File: rtl/multi_port_reg_file_if.sv
// Bus bundle for multi_port_reg_file: read/write port vectors, clear request
// and status outputs. clk/rst stay as plain ports on the block itself.
interface multi_port_reg_file_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 4,
    parameter int NUM_WR        = 2
);
    logic                              clear_req;
    logic [NUM_RD*ADDRESS_WIDTH-1:0]   rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]      rd_data;
    logic [NUM_WR-1:0]                 wr_en;
    logic [NUM_WR*ADDRESS_WIDTH-1:0]   wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0]      wr_data;
    logic                              ready;
    logic                              wr_conflict;
    logic [DATA_WIDTH-1:0]             a0;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, ready, wr_conflict, a0
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, ready, wr_conflict, a0
    );
endinterface

// File: rtl/multi_port_reg_file.sv
// Multi-port register file: NUM_RD combinational read ports, NUM_WR write
// ports (highest index wins on collision), register 0 hard-wired to zero,
// and an IDLE/CLEAR FSM that sweeps registers 1..2**ADDRESS_WIDTH-1 to zero
// after reset or on clear_req.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-cycle accepted
// write data to matching read ports (and a0).

// One read lane: stored value, optionally overridden by a matching write.
module multi_port_reg_file_rd_lane #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_WR        = 2,
    parameter bit BYPASS_EN     = 1'b0
) (
    input  logic [ADDRESS_WIDTH-1:0]        rd_addr,
    input  logic [DATA_WIDTH-1:0]           stored,
    input  logic [NUM_WR-1:0]               wr_acc,
    input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
    output logic [DATA_WIDTH-1:0]           rd_data
);
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp;

    // Scan write ports low to high so the highest matching port's data sticks.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_acc[j] && (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == rd_addr)) begin
                hit = 1'b1;
                byp = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_data = (BYPASS_EN && hit) ? byp : stored;
endmodule

module multi_port_reg_file #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 4,
    parameter int NUM_WR        = 2
) (
    input logic                 clk,
    input logic                 rst,
    multi_port_reg_file_if.slave bus
);
    localparam int NUM_REGS = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;
    logic                     ready_q;
    logic                     conflict_q;
    logic [DATA_WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_WR-1:0]        wr_acc;
    logic                     conflict;

    assign bus.ready       = ready_q;
    assign bus.wr_conflict = conflict_q;

    // A write is accepted only in IDLE, outside reset, to a non-zero address.
    always_comb begin
        wr_acc = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_acc[i] = (state == IDLE) && !rst && bus.wr_en[i] &&
                        (bus.wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0);
        end
    end

    // Any pair of accepted writes hitting the same address is a conflict.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_acc[i] && wr_acc[j] &&
                    (bus.wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                     bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]))
                    conflict = 1'b1;
            end
        end
    end

    // Array update: port writes in IDLE (later port overrides), sweep zero in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_acc[i])
                        mem[bus.wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <=
                            bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end else begin
                mem[clr_cnt] <= '0;
            end
        end
    end

    // Control FSM with registered ready/wr_conflict; reset starts a clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= ADDRESS_WIDTH'(1);
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    conflict_q <= conflict;
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= ADDRESS_WIDTH'(1);
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    conflict_q <= 1'b0;
                    if (&clr_cnt) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Read lanes: NUM_RD bus ports plus one extra lane observing register 10 as a0.
    for (genvar p = 0; p <= NUM_RD; p++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    stored;
        logic [DATA_WIDTH-1:0]    data;

        if (p < NUM_RD) begin : g_port
            assign addr = bus.rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        end else begin : g_a0
            assign addr   = A0_IDX;
            assign bus.a0 = data;
        end

        // Register 0 is never written, so it is forced to zero here.
        assign stored = (addr == '0) ? '0 : mem[addr];

        multi_port_reg_file_rd_lane #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .NUM_WR        (NUM_WR),
            .BYPASS_EN     (BYPASS_EN)
        ) u_lane (
            .rd_addr (addr),
            .stored  (stored),
            .wr_acc  (wr_acc),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (data)
        );
    end
endmodule
